main_memory_line_server: RTL and testbench
==========================================

// Module: main_memory_line_server
// PURPOSE
//  Memory-side responder for the I$ miss interface: accepts memory_request_t
//  line requests, queues them, returns each line after a fixed latency with the
//  requesting thread id and a bus-error flag. Sits between I$ miss port and the
//  backing line store; one response in flight, strictly in request order.
// PARAMETERS
//  LINE_WIDTH   128   bits per line (= `ICACHE_LINE_WIDTH)
//  ADDR_WIDTH   28    line address width (byte addr >> `ICACHE_RSH_VAL)
//  THR_WIDTH    1     thread id width (= `THR_PER_CORE_WIDTH)
//  LATENCY      10    accept-to-response cycles (= `MAIN_MEMORY_LATENCY), >=2
//  QUEUE_DEPTH  4     pending request slots, power of two
//  MEM_LINES    4096  lines in backing store
// PORTS
//  clock          in   1           system clock
//  reset          in   1           reset
//  req_valid      in   1           request valid (I$ req_valid_miss)
//  req_addr       in   ADDR_WIDTH  line address
//  req_is_store   in   1           1 = write req_data to line
//  req_data       in   LINE_WIDTH  store data
//  req_thread_id  in   THR_WIDTH   requesting thread
//  req_ready      out  1           queue can accept this cycle
//  rsp_valid      out  1           one-cycle response strobe (I$ rsp_valid_miss)
//  rsp_data       out  LINE_WIDTH  line data
//  rsp_bus_error  out  1           address out of range
//  rsp_thread_id  out  THR_WIDTH   thread of response
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: queue empty, FSM IDLE, counter 0, req_ready=1, rsp_valid=0,
//    rsp_data=0, rsp_bus_error=0, rsp_thread_id=0. Backing store NOT reset.
//  - Accept: req_valid & req_ready at edge -> push {addr,is_store,data,tid}.
//    req_ready = !full from registered count; pop in same cycle does NOT free a
//    slot for a same-cycle push when full. req_valid while !req_ready: dropped.
//  - FSM: IDLE -(queue non-empty)-> WAIT, load cnt=LATENCY-2;
//    WAIT: cnt-- ; at cnt==0 -> RESP; RESP: rsp_valid=1 one cycle, pop head,
//    store write (if is_store & in range) at this edge; -> WAIT (reload) if
//    queue still non-empty after pop, else IDLE.
//  - Latency: request accepted at edge T into empty idle server -> rsp_valid
//    high in cycle T+LATENCY. Back-to-back queued reqs: responses LATENCY
//    cycles apart.
//  - Read: rsp_data = store[addr] at RESP (sees earlier stores, in order).
//  - Store: response still issued, rsp_data = written data (ack).
//  - Outputs registered; rsp_data/tid/bus_error hold last values when
//    rsp_valid=0.
//  - Queue pointers wrap modulo QUEUE_DEPTH; count width clog2(DEPTH)+1.
//  - Reset mid-operation: queue flushed, pending responses lost, no strobe;
//    in-progress store not performed.
// CONFIGURATION
//  MEM_BUS_ERROR_EN defined: addr >= MEM_LINES -> rsp_bus_error=1,
//    rsp_data=0, store suppressed; ordering/latency unchanged.
//  Undefined: addr indexes modulo MEM_LINES, rsp_bus_error tied 0.
// TESTING
//  1 reset, store[5]=0xA5.., req addr=5 tid=1 at T -> rsp_valid at T+10,
//    data 0xA5.., tid=1, bus_error=0, single-cycle strobe.
//  2 4 reqs back-to-back (tid 0,1,0,1) -> req_ready low after 4th; responses
//    at T+10,+20,+30,+40 in order; 5th req while full dropped.
//  3 store addr 7 data 0x1234 then load addr 7 -> load rsp_data=0x1234.
//  4 addr=MEM_LINES: with MEM_BUS_ERROR_EN bus_error=1 data=0; without,
//    data=store[0], bus_error=0.
//  5 reset asserted at T+5 of pending load -> no rsp_valid; all outputs at
//    reset values; req_ready=1 after release.

Source files
------------

// File: rtl/main_memory_line_server_if.sv
// I$ miss-port bundle between the instruction cache (master) and the
// memory line server (slave).
interface main_memory_line_server_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 28,
  parameter int THR_WIDTH  = 1
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_is_store;
  logic [LINE_WIDTH-1:0] req_data;
  logic [THR_WIDTH-1:0]  req_thread_id;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [LINE_WIDTH-1:0] rsp_data;
  logic                  rsp_bus_error;
  logic [THR_WIDTH-1:0]  rsp_thread_id;

  modport master (
    output req_valid, req_addr, req_is_store, req_data, req_thread_id,
    input  req_ready, rsp_valid, rsp_data, rsp_bus_error, rsp_thread_id
  );
  modport slave (
    input  req_valid, req_addr, req_is_store, req_data, req_thread_id,
    output req_ready, rsp_valid, rsp_data, rsp_bus_error, rsp_thread_id
  );
endinterface

// File: rtl/main_memory_line_server.sv
// In-order line server for I$ misses: queues requests and answers each after a
// fixed latency. Define MEM_BUS_ERROR_EN to flag out-of-range addresses.
module main_memory_line_server #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int THR_WIDTH   = 1,
  parameter int LATENCY     = 10,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LINES   = 4096
) (
  input logic clock,
  input logic reset,
  main_memory_line_server_if.slave bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int IDX_W = $clog2(MEM_LINES);
`ifdef MEM_BUS_ERROR_EN
  localparam bit BUS_ERR_EN = 1'b1;
`else
  localparam bit BUS_ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_store;
    logic [LINE_WIDTH-1:0] data;
    logic [THR_WIDTH-1:0]  tid;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  req_t                  q [QUEUE_DEPTH];
  logic [LINE_WIDTH-1:0] mem [MEM_LINES];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic [CNT_W-1:0]      cnt;
  state_t                state;

  req_t             head;
  logic             push, pop, in_range;
  logic [IDX_W-1:0] mem_idx;

  // ready comes from the registered count only, so a full queue stays closed
  // even in the cycle its head is popped
  assign bus.req_ready = (count != (PTR_W+1)'(QUEUE_DEPTH));
  assign push          = bus.req_valid & bus.req_ready;
  assign pop           = (state == RESP);
  assign head          = q[rd_ptr];
  assign mem_idx       = head.addr[IDX_W-1:0];
  assign in_range      = !BUS_ERR_EN || (head.addr < ADDR_WIDTH'(MEM_LINES));

  always_ff @(posedge clock)
    if (push) q[wr_ptr] <= '{addr: bus.req_addr, is_store: bus.req_is_store,
                             data: bus.req_data, tid: bus.req_thread_id};

  // store lands at the RESP edge, after its own ack was formed
  always_ff @(posedge clock)
    if (pop && head.is_store && in_range) mem[mem_idx] <= head.data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_data      <= '0;
      bus.rsp_bus_error <= 1'b0;
      bus.rsp_thread_id <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (count != '0) begin
            state <= WAIT;
            cnt   <= CNT_W'(LATENCY - 2);
          end
        WAIT:
          if (cnt == '0) begin
            state             <= RESP;
            bus.rsp_valid     <= 1'b1;
            bus.rsp_thread_id <= head.tid;
            bus.rsp_bus_error <= !in_range;
            bus.rsp_data      <= !in_range     ? '0        :
                                 head.is_store ? head.data : mem[mem_idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        RESP:
          if (count > (PTR_W+1)'(1)) begin
            state <= WAIT;
            cnt   <= CNT_W'(LATENCY - 2);
          end else begin
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_line_server.sv
// Directed bench for main_memory_line_server: latency, ordering, back-pressure,
// store/load forwarding, out-of-range handling and mid-flight reset.
module tb_main_memory_line_server;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  main_memory_line_server_if #(.LINE_WIDTH(128), .ADDR_WIDTH(28), .THR_WIDTH(1)) bus ();

  main_memory_line_server dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [27:0] a, input logic st, input logic [127:0] d,
                      input logic t, output int acc);
    @(negedge clock);
    bus.req_valid     = 1'b1;
    bus.req_addr      = a;
    bus.req_is_store  = st;
    bus.req_data      = d;
    bus.req_thread_id = t;
    @(posedge clock);
    #1;
    acc           = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin
        at = cyc;
        return;
      end
    end
    n_chk++;
    n_bad++;
    $display("FAIL %s timeout waiting for rsp_valid", tag);
  endtask

  int t0, t1, ta, tmp, seen;
  logic [127:0] pat_a5, exp_d;
  logic [127:0] d2 [4];

  initial begin
    pat_a5 = {16{8'hA5}};
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_is_store = 1'b0;
    bus.req_data = '0; bus.req_thread_id = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data",  bus.rsp_data, 0);
    chk("rst_err",   bus.rsp_bus_error, 0);
    chk("rst_tid",   bus.rsp_thread_id, 0);
    @(negedge clock) reset = 1'b1;

    // 1: preload line 5, then load it and time the answer
    send(28'd5, 1'b1, pat_a5, 1'b0, t0);
    wait_rsp("t1_st", ta);
    chk("t1_st_ack", bus.rsp_data, pat_a5);
    send(28'd5, 1'b0, '0, 1'b1, t0);
    wait_rsp("t1_ld", ta);
    chk("t1_latency", 128'(ta - t0), 128'd10);
    chk("t1_data",    bus.rsp_data, pat_a5);
    chk("t1_tid",     bus.rsp_thread_id, 1);
    chk("t1_err",     bus.rsp_bus_error, 0);
    @(negedge clock);
    chk("t1_strobe",  bus.rsp_valid, 0);
    chk("t1_hold",    bus.rsp_data, pat_a5);

    // 2: fill the queue back-to-back, fifth request must be dropped
    for (int k = 0; k < 4; k++) d2[k] = 128'h1000 + 128'(k);
    send(28'd20, 1'b1, d2[0], 1'b0, t1);
    send(28'd21, 1'b1, d2[1], 1'b1, tmp);
    send(28'd22, 1'b1, d2[2], 1'b0, tmp);
    send(28'd23, 1'b1, d2[3], 1'b1, tmp);
    chk("t2_full", bus.req_ready, 0);
    send(28'd24, 1'b1, 128'hDEAD, 1'b1, tmp);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("t2_rsp", ta);
      chk("t2_time", 128'(ta - t1), 128'(10 * (k + 1)));
      chk("t2_data", bus.rsp_data, d2[k]);
      chk("t2_tid",  bus.rsp_thread_id, 128'(k % 2));
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
    end
    chk("t2_dropped", 128'(seen), 0);
    chk("t2_ready",   bus.req_ready, 1);

    // 3: store then load forwards through the backing store
    send(28'd7, 1'b1, 128'h1234, 1'b0, t0);
    wait_rsp("t3_st", ta);
    chk("t3_st_ack", bus.rsp_data, 128'h1234);
    send(28'd7, 1'b0, '0, 1'b0, t0);
    wait_rsp("t3_ld", ta);
    chk("t3_ld_data", bus.rsp_data, 128'h1234);

    // 4: address one past the end of the store
    send(28'd0, 1'b1, 128'hBEEF, 1'b0, t0);
    wait_rsp("t4_st", ta);
    send(28'd4096, 1'b0, '0, 1'b1, t0);
    wait_rsp("t4_ld", ta);
`ifdef MEM_BUS_ERROR_EN
    exp_d = '0;
    chk("t4_err", bus.rsp_bus_error, 1);
`else
    exp_d = 128'hBEEF;
    chk("t4_err", bus.rsp_bus_error, 0);
`endif
    chk("t4_data",    bus.rsp_data, exp_d);
    chk("t4_latency", 128'(ta - t0), 128'd10);

    // 5: reset mid-flight kills the pending load
    send(28'd5, 1'b0, '0, 1'b1, t0);
    seen = 0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", bus.rsp_valid, 0);
    chk("t5_data",  bus.rsp_data, 0);
    chk("t5_err",   bus.rsp_bus_error, 0);
    chk("t5_tid",   bus.rsp_thread_id, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    chk("t5_ready", bus.req_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
    end
    chk("t5_no_rsp", 128'(seen), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
